// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the 6502 core: reads opcode plus operands at PC,
// hands them to the decoder, and lends the shared memory bus to the decoder while it executes.
module fetch_sequencer #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 16'h0200,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_we,
    output logic [REG_WIDTH-1:0]  mem_wdata,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    input  logic                  mem_ack,
    output logic [REG_WIDTH-1:0]  instruction_out,
    output logic [15:0]           operand_out,
    output logic [ADDR_WIDTH-1:0] address_out,
    output logic                  instruction_ready,
    input  logic                  instruction_done,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_val,
    input  logic                  dreq,
    input  logic                  dwe,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [REG_WIDTH-1:0]  dwdata,
    output logic                  dgrant,
    output logic                  dack,
    output logic                  fault
);

    typedef enum logic [2:0] {IDLE, FETCH_OP, FETCH_LO, FETCH_HI, EXEC, HALT} state_t;

    localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [1:0]            len;
    logic [3:0]            wait_cnt;
    logic [1:0]            op_len;

    // Operand byte count decoded from the aaa/bbb/cc opcode fields.
    function automatic logic [1:0] operand_len(input logic [7:0] op);
        logic [1:0] n;
        logic [2:0] bbb;
        bbb = op[4:2];
        n   = 2'd0;
        case (op[1:0])
            2'b01: n = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd2 : 2'd1;
            2'b11: n = 2'd0;
            default: begin
                case (bbb)
                    3'b011, 3'b111:         n = 2'd2;
                    3'b001, 3'b101, 3'b100: n = 2'd1;
                    3'b010, 3'b110:         n = 2'd0;
                    default: begin
                        if (op == 8'h20)
                            n = 2'd2;
                        else if (op == 8'h00 || op == 8'h40 || op == 8'h60)
                            n = 2'd0;
                        else
                            n = 2'd1;
                    end
                endcase
            end
        endcase
        return n;
    endfunction

    assign pc_next = pc + ADDR_WIDTH'(1);
    assign op_len  = operand_len(mem_rdata[7:0]);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= IDLE;
            pc                <= RESET_PC;
            len               <= 2'd0;
            wait_cnt          <= 4'd0;
            instruction_out   <= '0;
            operand_out       <= '0;
            address_out       <= '0;
            instruction_ready <= 1'b0;
            fault             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state    <= FETCH_OP;
                        wait_cnt <= 4'd0;
                    end
                end
                FETCH_OP, FETCH_LO, FETCH_HI: begin
                    if (!mem_ack) begin
                        // Only fetch reads are timed; a stalled bus parks the core for good.
                        if (wait_cnt == LAST_WAIT) begin
                            fault <= 1'b1;
                            state <= HALT;
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end else begin
                        wait_cnt <= 4'd0;
                        pc       <= pc_next;
                        case (state)
                            FETCH_OP: begin
                                instruction_out <= mem_rdata;
                                address_out     <= pc;
                                operand_out     <= '0;
                                len             <= op_len;
                                if (op_len == 2'd0) begin
                                    state             <= EXEC;
                                    instruction_ready <= 1'b1;
                                end else begin
                                    state <= FETCH_LO;
                                end
                            end
                            FETCH_LO: begin
                                operand_out[7:0] <= mem_rdata[7:0];
                                if (len == 2'd1) begin
                                    state             <= EXEC;
                                    instruction_ready <= 1'b1;
                                end else begin
                                    state <= FETCH_HI;
                                end
                            end
                            default: begin
                                operand_out[15:8] <= mem_rdata[7:0];
                                state             <= EXEC;
                                instruction_ready <= 1'b1;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (instruction_done) begin
                        instruction_ready <= 1'b0;
                        wait_cnt          <= 4'd0;
                        if (pc_load)
                            pc <= pc_load_val;
                        state <= run ? FETCH_OP : IDLE;
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        dgrant    = 1'b0;
        dack      = 1'b0;
        case (state)
            FETCH_OP, FETCH_LO, FETCH_HI: begin
                mem_rd   = 1'b1;
                mem_addr = pc;
            end
            EXEC: begin
                // The completing cycle belongs to the next fetch, so a late dreq is refused.
                if (dreq && !instruction_done) begin
                    dgrant    = 1'b1;
                    mem_addr  = daddr;
                    mem_rd    = ~dwe;
                    mem_we    = dwe;
                    mem_wdata = dwdata;
                    dack      = mem_ack;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a toggling memory responder checks fetch addresses
// against a scoreboard, and a monitor checks each presented instruction against expectations.
module tb_fetch_sequencer;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] opnd;
        logic [15:0] addr;
    } instr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic [7:0]  instruction_out;
    logic [15:0] operand_out;
    logic [15:0] address_out;
    logic        instruction_ready;
    logic        instruction_done;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        dreq;
    logic        dwe;
    logic [15:0] daddr;
    logic [7:0]  dwdata;
    logic        dgrant;
    logic        dack;
    logic        fault;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_rd_q [$];
    instr_t      exp_instr_q [$];
    logic        ack_en = 1'b1;
    logic        ready_q = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    fetch_sequencer dut (
        .clk(clk), .reset_n(reset_n), .run(run),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .instruction_out(instruction_out), .operand_out(operand_out), .address_out(address_out),
        .instruction_ready(instruction_ready), .instruction_done(instruction_done),
        .pc_load(pc_load), .pc_load_val(pc_load_val),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
        .dgrant(dgrant), .dack(dack), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder: ack toggles, so each access completes one cycle after its strobe.
    always @(negedge clk) begin
        #2;
        if (ack_en && !mem_ack && (mem_rd || mem_we)) begin
            mem_ack = 1'b1;
            if (mem_rd) mem_rdata = mem[mem_addr];
            if (mem_we) mem[mem_addr] = mem_wdata;
            if (mem_rd && !dgrant) begin
                if (exp_rd_q.size() == 0)
                    check("fetch_addr_unexpected", {16'h0, mem_addr}, 32'hDEAD_BEEF);
                else
                    check("fetch_addr", {16'h0, mem_addr}, {16'h0, exp_rd_q.pop_front()});
            end
        end else begin
            mem_ack = 1'b0;
        end
    end

    // Instruction monitor: compares on each rising instruction_ready.
    always @(posedge clk) begin
        #1;
        if (instruction_ready && !ready_q) begin
            if (exp_instr_q.size() == 0) begin
                check("instr_unexpected", {8'h0, instruction_out, address_out}, 32'hDEAD_BEEF);
            end else begin
                instr_t e;
                e = exp_instr_q.pop_front();
                check("instruction_out", {24'h0, instruction_out}, {24'h0, e.op});
                check("operand_out", {16'h0, operand_out}, {16'h0, e.opnd});
                check("address_out", {16'h0, address_out}, {16'h0, e.addr});
            end
        end
        ready_q = instruction_ready;
    end

    // Place an instruction in memory and queue the reads and decoder view it should produce.
    task automatic prog(input logic [15:0] a, input int n,
                        input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        instr_t e;
        logic [15:0] a1, a2;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        mem[a] = b0;
        exp_rd_q.push_back(a);
        if (n >= 1) begin mem[a1] = b1; exp_rd_q.push_back(a1); end
        if (n == 2) begin mem[a2] = b2; exp_rd_q.push_back(a2); end
        e.op   = b0;
        e.opnd = {(n == 2) ? b2 : 8'h00, (n >= 1) ? b1 : 8'h00};
        e.addr = a;
        exp_instr_q.push_back(e);
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (instruction_ready) break;
        end
        check(tag, {31'h0, instruction_ready}, 32'h1);
    endtask

    task automatic done_pulse(input logic ld, input logic [15:0] val);
        @(negedge clk);
        instruction_done = 1'b1;
        pc_load          = ld;
        pc_load_val      = val;
        @(negedge clk);
        instruction_done = 1'b0;
        pc_load          = 1'b0;
    endtask

    initial begin
        int cnt;
        reset_n = 1'b0; run = 1'b0; instruction_done = 1'b0; pc_load = 1'b0;
        pc_load_val = 16'h0; dreq = 1'b0; dwe = 1'b0; daddr = 16'h0; dwdata = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, instruction_ready}, 32'h0);
        check("rst_fault", {31'h0, fault}, 32'h0);
        check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        check("rst_instr", {24'h0, instruction_out}, 32'h0);
        check("rst_operand", {16'h0, operand_out}, 32'h0);

        // LDA #$42, then INX, then LDA $1234
        prog(16'h0200, 1, 8'hA9, 8'h42, 8'h00);
        @(negedge clk); reset_n = 1'b1; run = 1'b1;
        wait_ready("ready_lda_imm");
        prog(16'h0202, 0, 8'hE8, 8'h00, 8'h00);
        done_pulse(1'b0, 16'h0);
        wait_ready("ready_inx");
        prog(16'h0203, 2, 8'hAD, 8'h34, 8'h12);
        done_pulse(1'b0, 16'h0);
        wait_ready("ready_lda_abs");

        // Decoder write granted in EXEC
        @(negedge clk);
        ack_en = 1'b0; dreq = 1'b1; dwe = 1'b1; daddr = 16'h0300; dwdata = 8'h55;
        #1;
        check("exec_dgrant", {31'h0, dgrant}, 32'h1);
        check("exec_mem_we", {31'h0, mem_we}, 32'h1);
        check("exec_mem_addr", {16'h0, mem_addr}, 32'h0000_0300);
        check("exec_mem_wdata", {24'h0, mem_wdata}, 32'h55);
        // Decoder read acked through dack
        @(negedge clk);
        dwe = 1'b0; ack_en = 1'b1;
        #3;
        check("exec_mem_rd", {31'h0, mem_rd}, 32'h1);
        check("exec_dack", {31'h0, dack}, 32'h1);
        // Completion with a jump while dreq is still high
        @(negedge clk);
        ack_en = 1'b0; dwe = 1'b1;
        prog(16'hC000, 0, 8'hE8, 8'h00, 8'h00);
        instruction_done = 1'b1; pc_load = 1'b1; pc_load_val = 16'hC000;
        #1;
        check("done_dgrant", {31'h0, dgrant}, 32'h0);
        @(posedge clk); #1;
        check("fetch_dgrant", {31'h0, dgrant}, 32'h0);
        check("fetch_mem_we", {31'h0, mem_we}, 32'h0);
        check("fetch_mem_rd", {31'h0, mem_rd}, 32'h1);
        check("jump_addr", {16'h0, mem_addr}, 32'h0000_C000);
        check("ready_drop", {31'h0, instruction_ready}, 32'h0);
        @(negedge clk);
        instruction_done = 1'b0; pc_load = 1'b0; dreq = 1'b0; dwe = 1'b0; ack_en = 1'b1;
        wait_ready("ready_jump");

        // Wrap across FFFF while fetching operands
        prog(16'hFFFE, 2, 8'hAD, 8'hCD, 8'hAB);
        done_pulse(1'b1, 16'hFFFE);
        wait_ready("ready_wrap");
        prog(16'h0001, 0, 8'hEA, 8'h00, 8'h00);
        done_pulse(1'b0, 16'h0);
        wait_ready("ready_after_wrap");

        // Bus timeout on the next opcode read at 0002
        @(negedge clk);
        instruction_done = 1'b1; ack_en = 1'b0;
        @(posedge clk); #1;
        check("to_rd_start", {31'h0, mem_rd}, 32'h1);
        @(negedge clk); instruction_done = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (fault) break;
        end
        check("to_cycles", cnt, 32'd15);
        check("to_fault", {31'h0, fault}, 32'h1);
        check("to_mem_rd", {31'h0, mem_rd}, 32'h0);
        @(negedge clk); ack_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("halt_fault", {31'h0, fault}, 32'h1);
        check("halt_mem_rd", {31'h0, mem_rd}, 32'h0);
        check("halt_ready", {31'h0, instruction_ready}, 32'h0);

        // Reset clears the fault; restart at 0200 and reset again mid operand fetch
        @(negedge clk); reset_n = 1'b0;
        @(posedge clk); #1;
        check("rst2_fault", {31'h0, fault}, 32'h0);
        exp_rd_q.push_back(16'h0200);
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (mem_rd && mem_addr == 16'h0201) break;
        end
        check("lo_reached", {16'h0, mem_addr}, 32'h0000_0201);
        @(negedge clk); reset_n = 1'b0; ack_en = 1'b0;
        @(posedge clk); #1;
        check("rst3_ready", {31'h0, instruction_ready}, 32'h0);
        check("rst3_mem_rd", {31'h0, mem_rd}, 32'h0);
        check("rst3_instr", {24'h0, instruction_out}, 32'h0);
        check("rst3_addr_out", {16'h0, address_out}, 32'h0);
        prog(16'h0200, 1, 8'hA9, 8'h42, 8'h00);
        @(negedge clk); reset_n = 1'b1; ack_en = 1'b1;
        wait_ready("ready_restart");

        // Remaining length classes: JSR, RTS, ADC abs,Y, cc=11, ADC zp
        prog(16'h0202, 2, 8'h20, 8'h00, 8'h30);
        done_pulse(1'b0, 16'h0);
        wait_ready("ready_jsr");
        prog(16'h0205, 0, 8'h60, 8'h00, 8'h00);
        done_pulse(1'b0, 16'h0);
        wait_ready("ready_rts");
        prog(16'h0206, 2, 8'h79, 8'h11, 8'h22);
        done_pulse(1'b0, 16'h0);
        wait_ready("ready_adc_absy");
        prog(16'h0209, 0, 8'h03, 8'h00, 8'h00);
        done_pulse(1'b0, 16'h0);
        wait_ready("ready_cc11");
        prog(16'h020A, 1, 8'h65, 8'h77, 8'h00);
        done_pulse(1'b0, 16'h0);
        wait_ready("ready_adc_zp");

        // Completion with run low parks in IDLE
        @(negedge clk); run = 1'b0;
        done_pulse(1'b0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_mem_rd", {31'h0, mem_rd}, 32'h0);
        check("idle_ready", {31'h0, instruction_ready}, 32'h0);
        check("rd_q_drained", exp_rd_q.size(), 32'd0);
        check("instr_q_drained", exp_instr_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch for the 6502 core.
- Reads opcode and 0-2 operand bytes from memory at PC, then presents them to the decoder with a level instruction_ready, and waits for instruction_done.
- Owns the single memory bus and arbitrates it between its own fetch engine and the decoder's data-access port.
- Sits between the memory model and the decoder/datapath.

Parameters:
- REG_WIDTH, 8, data/opcode width.
- ADDR_WIDTH, 16, address width.
- RESET_PC, 16'h0200, PC value loaded on reset.
- TIMEOUT, 15, maximum cycles to wait for mem_ack before faulting (4-bit counter).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- run  in  1  enable; sampled in IDLE and at instruction completion
- mem_addr  out  ADDR_WIDTH  memory address
- mem_rd  out  1  read strobe
- mem_we  out  1  write strobe
- mem_wdata  out  REG_WIDTH  write data
- mem_rdata  in  REG_WIDTH  read data, valid when mem_ack=1
- mem_ack  in  1  access complete
- instruction_out  out  REG_WIDTH  latched opcode
- operand_out  out  16  latched operand, {hi,lo}; unused bytes are 0
- address_out  out  ADDR_WIDTH  PC of the opcode
- instruction_ready  out  1  instruction valid to decoder
- instruction_done  in  1  decoder finished
- pc_load  in  1  with instruction_done: load pc_load_val as next PC
- pc_load_val  in  ADDR_WIDTH  jump/branch target
- dreq  in  1  decoder data request
- dwe  in  1  decoder write (1) / read (0)
- daddr  in  ADDR_WIDTH  decoder data address
- dwdata  in  REG_WIDTH  decoder write data
- dgrant  out  1  decoder owns the bus this cycle
- dack  out  1  mem_ack forwarded to decoder while granted
- fault  out  1  sticky bus-timeout flag

Behaviour:
- Reset (clk edge with reset_n=0; also mid-operation):
  - state=IDLE, PC=RESET_PC.
  - All outputs 0, including fault. Latched instruction/operand cleared.
- States: IDLE, FETCH_OP, FETCH_LO, FETCH_HI, EXEC, HALT.
- IDLE: if run=1, go to FETCH_OP next cycle.
- FETCH_OP:
  - mem_rd=1, mem_addr=PC.
  - On mem_ack: latch opcode into instruction_out, address_out=PC, PC=PC+1, operand_out=0, compute len.
  - len=0 -> EXEC; else -> FETCH_LO.
- FETCH_LO: read at PC; on ack latch operand_out[7:0], PC+1; len=1 -> EXEC, else -> FETCH_HI.
- FETCH_HI: read at PC; on ack latch operand_out[15:8], PC+1 -> EXEC.
- Operand length from opcode fields aaa=[7:5], bbb=[4:2], cc=[1:0]:
  - cc=01: bbb 011/110/111 -> 2, otherwise 1.
  - cc=00 or 10:
    - bbb 011/111 -> 2.
    - bbb 001/101/100 -> 1.
    - bbb 010/110 -> 0.
    - bbb 000: opcode 20 -> 2; 00/40/60 -> 0; otherwise 1.
  - cc=11 -> 0.
- EXEC:
  - instruction_ready=1 (registered, rises on entry, held until completion). instruction_out/operand_out/address_out stable throughout.
  - Bus is granted to the decoder: dgrant=dreq, mem_addr=daddr, mem_rd=dreq&~dwe, mem_we=dreq&dwe, mem_wdata=dwdata, dack=mem_ack.
  - On instruction_done=1:
    - PC = pc_load ? pc_load_val : PC.
    - instruction_ready=0 next cycle.
    - run=1 -> FETCH_OP; run=0 -> IDLE.
    - Any dreq in the same cycle is ignored (not granted).
- Outside EXEC: dgrant=0, dack=0, dreq stalls. mem_we=0 during fetch.
- PC arithmetic: modulo 2^ADDR_WIDTH; FFFF+1 -> 0000, including mid-operand fetch.
- Timeout:
  - The wait counter clears on each new access and on ack, and increments each cycle the fetch read is pending.
  - Reaching TIMEOUT -> fault=1, state HALT.
  - HALT: all strobes 0, instruction_ready=0; exit only by reset.
  - Decoder accesses in EXEC are not timed.
- mem_ack outside a pending access is ignored.
- run deasserting mid-fetch does not abort; it is only checked at IDLE/completion.

Test Plan:
- LDA immediate: reset, run=1, mem 0200=A9, 0201=42, ack 1 cycle after rd.
  - Expect reads at 0200, 0201.
  - instruction_out=A9, operand_out=0042, address_out=0200, instruction_ready rises.
  - Pulse done -> next fetch at 0202.
- Absolute: 0200=AD 34 12 -> three reads, operand_out=1234. Implied 0200=E8 -> one read, operand_out=0000, next fetch 0201.
- Arbitration: in EXEC, dreq=1, dwe=1, daddr=0300, dwdata=55 -> mem_we=1, mem_addr=0300, dgrant=1. Same dreq during FETCH_OP -> dgrant=0, mem_we=0.
- Jump and wrap:
  - done with pc_load=1, pc_load_val=C000 -> next fetch at C000.
  - Opcode AD at FFFE -> operand reads at FFFF then 0000.
- Timeout: withhold mem_ack 15 cycles in FETCH_OP -> fault=1, mem_rd=0 thereafter; reset clears fault and restarts at 0200.
- Reset mid-FETCH_LO -> next cycle state IDLE, instruction_ready=0, PC=0200.
